// File: rtl/seq_divider_param.sv
// Multicycle restoring divider: one quotient bit per clock, signed or unsigned operands,
// start/busy/done handshake with divide-by-zero and signed-overflow flags.
module seq_divider_param #(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    typedef enum logic [1:0] {
        StIdle,
        StIter,
        StFix,
        StDone
    } state_e;

    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH - 1){1'b0}}};

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] n_q, n_d;        // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] d_q, d_d;
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
    logic             neg_quot_q, neg_quot_d;
    logic             neg_rem_q, neg_rem_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_out_q, rem_out_d;
    logic             dz_q, dz_d;
    logic             ovf_q, ovf_d;

    logic             dvd_neg, dvs_neg;
    logic [WIDTH-1:0] dvd_mag, dvs_mag;
    logic [WIDTH:0]   r_shift;
    logic             r_ge_d;

    always_comb begin
        dvd_neg = signed_mode & dividend[WIDTH-1];
        dvs_neg = signed_mode & divisor[WIDTH-1];
        dvd_mag = dvd_neg ? WIDTH'(0) - dividend : dividend;
        dvs_mag = dvs_neg ? WIDTH'(0) - divisor : divisor;
        r_shift = {rem_q, n_q[WIDTH-1]};
        r_ge_d  = r_shift >= {1'b0, d_q};
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        n_d        = n_q;
        d_d        = d_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        ovf_pend_d = ovf_pend_q;
        busy_d     = busy_q;
        done_d     = done_q;
        quot_d     = quot_q;
        rem_out_d  = rem_out_q;
        dz_d       = dz_q;
        ovf_d      = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    dz_d       = 1'b0;
                    ovf_d      = 1'b0;
                    neg_quot_d = dvd_neg ^ dvs_neg;
                    neg_rem_d  = dvd_neg;
                    ovf_pend_d = signed_mode && (dividend == MinVal) && (divisor == '1);
                    d_d        = dvs_mag;
                    rem_d      = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    if (divisor == '0) begin
                        // Raw dividend kept so it can be returned as the remainder.
                        n_d     = dividend;
                        state_d = StDone;
                    end else begin
                        n_d     = dvd_mag;
                        state_d = StIter;
                    end
                end
            end
            StIter: begin
                if (r_ge_d) begin
                    rem_d = WIDTH'(r_shift - {1'b0, d_q});
                    n_d   = {n_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = r_shift[WIDTH-1:0];
                    n_d   = {n_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                // MIN / -1 wraps naturally: magnitude 2^(WIDTH-1) with a positive sign.
                quot_d    = neg_quot_q ? WIDTH'(0) - n_q : n_q;
                rem_out_d = neg_rem_q ? WIDTH'(0) - rem_q : rem_q;
                ovf_d     = ovf_pend_q;
                busy_d    = 1'b0;
                done_d    = 1'b1;
                state_d   = StDone;
            end
            StDone: begin
                if (done_q) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    // Divide-by-zero path arrives here straight from idle.
                    quot_d    = '1;
                    rem_out_d = n_q;
                    dz_d      = 1'b1;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            n_q        <= '0;
            d_q        <= '0;
            rem_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quot_q     <= '0;
            rem_out_q  <= '0;
            dz_q       <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            n_q        <= n_d;
            d_q        <= d_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            ovf_pend_q <= ovf_pend_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            quot_q     <= quot_d;
            rem_out_q  <= rem_out_d;
            dz_q       <= dz_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_out_q;
    assign div_by_zero = dz_q;
    assign overflow    = ovf_q;

endmodule
